// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture sequencer in front of a combinational ALU.
// Optional divide-by-zero trap: define ALU_SEQ_DIV0_TRAP_EN.
//
// state | meaning
// IDLE  | waiting for a queued command
// EXEC  | operands on alu_*, ALU settling; capture at next edge
// RESP  | response held on rsp_* until rsp_ready
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_opcode,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic [W-1:0] alu_A,
   output logic [W-1:0] alu_B,
   output logic [2:0]   alu_opcode,
   input  logic [W-1:0] alu_result,
   input  logic [W-1:0] alu_remainder,
   input  logic         alu_zero,
   input  logic         alu_overflow,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [2:0]   rsp_opcode,
   output logic [W-1:0] rsp_result,
   output logic [W-1:0] rsp_remainder,
   output logic         rsp_zero,
   output logic         rsp_overflow,
   output logic         rsp_div0,
   output logic         busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } cmd_t;

   state_t         state, state_nxt;
   cmd_t           mem [DEPTH];
   cmd_t           head;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           full, empty, push, pop, issue, capture, rsp_hs;

   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      rsp_hs    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_hs = 1'b1;
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ALU_SEQ_DIV0_TRAP_EN
   logic         head_trap, trap_q;
   logic [W-1:0] trap_a_q;

   // a trapped divide never reaches the ALU, so alu_* keep the previous operation
   assign head_trap = (head.op == OP_DIV) && (head.b == '0);
   assign issue     = pop && !head_trap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q   <= 1'b0;
         trap_a_q <= '0;
      end else if (pop) begin
         trap_q   <= head_trap;
         trap_a_q <= head.a;
      end
   end
`else
   assign issue    = pop;
   assign rsp_div0 = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_A      <= '0;
         alu_B      <= '0;
         alu_opcode <= '0;
      end else if (issue) begin
         alu_opcode <= head.op;
         alu_A      <= head.a;
         alu_B      <= head.b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid     <= 1'b0;
         rsp_opcode    <= '0;
         rsp_result    <= '0;
         rsp_remainder <= '0;
         rsp_zero      <= 1'b0;
         rsp_overflow  <= 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
         rsp_div0      <= 1'b0;
`endif
      end else if (capture) begin
         rsp_valid     <= 1'b1;
         rsp_opcode    <= alu_opcode;
         rsp_result    <= alu_result;
         // the ALU leaves a stale remainder on non-divide ops
         rsp_remainder <= (alu_opcode == OP_DIV) ? alu_remainder : '0;
         rsp_zero      <= alu_zero;
         rsp_overflow  <= alu_overflow;
`ifdef ALU_SEQ_DIV0_TRAP_EN
         rsp_div0      <= trap_q;
         if (trap_q) begin
            rsp_opcode    <= OP_DIV;
            rsp_result    <= '1;
            rsp_remainder <= trap_a_q;
            rsp_zero      <= 1'b0;
            rsp_overflow  <= 1'b1;
         end
`endif
      end else if (rsp_hs) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, response queue model and directed tests.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int W     = 4;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] res;
      logic [W-1:0] rem;
      logic         z;
      logic         ov;
      logic         d0;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_opcode = '0;
   logic [W-1:0] cmd_a = '0, cmd_b = '0;
   logic [W-1:0] alu_A, alu_B;
   logic [2:0]   alu_opcode;
   logic [W-1:0] alu_result, alu_remainder;
   logic         alu_zero, alu_overflow;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [2:0]   rsp_opcode;
   logic [W-1:0] rsp_result, rsp_remainder;
   logic         rsp_zero, rsp_overflow, rsp_div0, busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_hs = 0;
   int   last_hs = -1;
   bit   tp_mode = 1'b0;
   rsp_t exp_q[$];
   rsp_t e_cur;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_remainder(alu_remainder),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
      .rsp_result(rsp_result), .rsp_remainder(rsp_remainder),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_div0(rsp_div0),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational ALU: {result, remainder, zero, overflow}; remainder is a%b regardless of op
   function automatic logic [2*W+1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]     s;
      logic [2*W-1:0] p;
      logic [W-1:0]   r, rm;
      logic           ov;
      ov = 1'b0;
      rm = (b != '0) ? a % b : a;
      r  = '0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; ov = s[W]; end
         3'd1: begin r = a - b; ov = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; ov = |p[2*W-1:W]; end
         default: r = (b != '0) ? a / b : '0;
      endcase
      return {r, rm, (r == '0), ov};
   endfunction

   function automatic rsp_t model_rsp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      rsp_t           m;
      logic [2*W+1:0] o;
      o    = alu_fn(op, a, b);
      m.op = op;
      m.res = o[2*W+1:W+2];
      m.rem = (op == 3'd7) ? o[W+1:2] : '0;
      m.z  = o[1];
      m.ov = o[0];
      m.d0 = 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
      if (op == 3'd7 && b == '0) begin
         m.res = '1; m.rem = a; m.z = 1'b0; m.ov = 1'b1; m.d0 = 1'b1;
      end
`endif
      return m;
   endfunction

   always_comb {alu_result, alu_remainder, alu_zero, alu_overflow} = alu_fn(alu_opcode, alu_A, alu_B);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every falling edge against the expected-response queue
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         check("busy", 32'(busy), 32'(exp_q.size() != 0));
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
               e_cur = exp_q[0];
               check("rsp_opcode",    32'(rsp_opcode),    32'(e_cur.op));
               check("rsp_result",    32'(rsp_result),    32'(e_cur.res));
               check("rsp_remainder", 32'(rsp_remainder), 32'(e_cur.rem));
               check("rsp_zero",      32'(rsp_zero),      32'(e_cur.z));
               check("rsp_overflow",  32'(rsp_overflow),  32'(e_cur.ov));
               check("rsp_div0",      32'(rsp_div0),      32'(e_cur.d0));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  n_hs++;
                  if (tp_mode && last_hs >= 0) check("rsp spacing", 32'(cyc - last_hs), 32'd2);
                  last_hs = cyc;
               end
            end
         end
         if (cmd_valid && cmd_ready) exp_q.push_back(model_rsp(cmd_opcode, cmd_a, cmd_b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
      int n;
      n = 0;
      acc = 1'b0;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = cmd_ready;
         tick();
         n++;
      end
      cmd_valid = 1'b0;
      if (!acc) check("send timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      if (!seen) check("wait_rsp timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = !busy;
      end
      if (!done) check("wait_idle timeout", 32'd0, 32'd1);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n_acc, seen;

      // model pins
      check("model add 7+9",  32'(model_rsp(3'd0, 4'd7, 4'd9)),   32'({3'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0}));
      check("model div 13/4", 32'(model_rsp(3'd7, 4'd13, 4'd4)),  32'({3'd7, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0}));
      check("model and C&A",  32'(model_rsp(3'd2, 4'hC, 4'hA)),   32'({3'd2, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0}));

      // reset values
      @(negedge clk);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset busy",      32'(busy),      32'd0);
      check("reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset alu",       32'({alu_opcode, alu_A, alu_B}), 32'd0);
      check("reset rsp data",  32'({rsp_opcode, rsp_result, rsp_remainder, rsp_zero, rsp_overflow, rsp_div0}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // add 7+9: latency
      rsp_ready = 1'b1;
      send(3'd0, 4'd7, 4'd9, acc);
      @(posedge clk);
      @(negedge clk);
      check("lat alu_A",          32'(alu_A),      32'd7);
      check("lat alu_B",          32'(alu_B),      32'd9);
      check("lat rsp_valid edge1", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("lat rsp_valid edge2", 32'(rsp_valid),  32'd1);
      check("add result",          32'(rsp_result), 32'd0);
      check("add zero",            32'(rsp_zero),   32'd1);
      check("add overflow",        32'(rsp_overflow), 32'd1);
      wait_idle();

      // divide then AND
      rsp_ready = 1'b0;
      send(3'd7, 4'd13, 4'd4, acc);
      send(3'd2, 4'hC, 4'hA, acc);
      wait_rsp();
      check("div result",    32'(rsp_result),    32'd3);
      check("div remainder", 32'(rsp_remainder), 32'd1);
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      wait_rsp();
      check("and result",    32'(rsp_result),    32'd8);
      check("and remainder", 32'(rsp_remainder), 32'd0);
      tick();
      rsp_ready = 1'b1;
      wait_idle();

      // backpressure
      rsp_ready = 1'b0;
      n_acc = 0;
      send(3'd0, 4'd1,  4'd2,  acc); n_acc += int'(acc);
      send(3'd1, 4'd3,  4'd5,  acc); n_acc += int'(acc);
      send(3'd3, 4'd4,  4'd8,  acc); n_acc += int'(acc);
      send(3'd4, 4'd15, 4'd15, acc); n_acc += int'(acc);
      send(3'd6, 4'd3,  4'd5,  acc); n_acc += int'(acc);
      check("bp accepts", 32'(n_acc), 32'(DEPTH + 1));
      cmd_valid = 1'b1; cmd_opcode = 3'd5; cmd_a = 4'd1; cmd_b = 4'd1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp cmd_ready full", 32'(cmd_ready), 32'd0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();

      // throughput with wrap-around
      tp_mode = 1'b1;
      last_hs = -1;
      n_hs = 0;
      for (int i = 0; i < 8; i++) send(3'(i), 4'(i * 3 + 1), 4'(i + 1), acc);
      wait_idle();
      check("tp responses", 32'(n_hs), 32'd8);
      tp_mode = 1'b0;

      // divide by zero
      send(3'd1, 4'd9, 4'd2, acc);
      wait_idle();
      rsp_ready = 1'b0;
      send(3'd7, 4'd6, 4'd0, acc);
      wait_rsp();
`ifdef ALU_SEQ_DIV0_TRAP_EN
      check("div0 result",   32'(rsp_result),    32'hF);
      check("div0 rem",      32'(rsp_remainder), 32'd6);
      check("div0 flag",     32'(rsp_div0),      32'd1);
      check("div0 overflow", 32'(rsp_overflow),  32'd1);
      check("div0 alu held", 32'({alu_opcode, alu_A, alu_B}), 32'({3'd1, 4'd9, 4'd2}));
`else
      check("div0 result",   32'(rsp_result),    32'd0);
      check("div0 rem",      32'(rsp_remainder), 32'd6);
      check("div0 flag",     32'(rsp_div0),      32'd0);
      check("div0 zero",     32'(rsp_zero),      32'd1);
      check("div0 alu",      32'({alu_opcode, alu_A, alu_B}), 32'({3'd7, 4'd6, 4'd0}));
`endif
      tick();
      rsp_ready = 1'b1;
      wait_idle();

      // reset mid-EXEC with three queued
      rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) send(3'd0, 4'(i), 4'd1, acc);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst busy",      32'(busy),      32'd0);
      check("rst cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst rsp data",  32'({rsp_opcode, rsp_result, rsp_remainder, rsp_zero, rsp_overflow, rsp_div0}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("no rsp after reset", 32'(seen), 32'd0);
      check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 4-bit ALU interface: accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Drives registered A/B/opcode into the combinational ALU, captures result/remainder/flags one cycle later and returns them on a valid/ready response stream.
- Sits between the control FSM / command source and the ALU datapath.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- W, 4, operand/result width; must match the ALU width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full
- cmd_opcode  input  3  ALU opcode (000 add … 111 divide)
- cmd_a  input  W  operand A
- cmd_b  input  W  operand B
- alu_A  output  W  registered operand A to ALU
- alu_B  output  W  registered operand B to ALU
- alu_opcode  output  3  registered opcode to ALU
- alu_result  input  W  ALU result
- alu_remainder  input  W  ALU remainder
- alu_zero  input  1  ALU zeroFlag
- alu_overflow  input  1  ALU overflowFlag
- rsp_valid  output  1  response held stable until accepted
- rsp_ready  input  1  consumer accepts response
- rsp_opcode  output  3  opcode of this response
- rsp_result  output  W  captured result
- rsp_remainder  output  W  captured remainder; 0 for non-divide opcodes
- rsp_zero  output  1  captured zero flag
- rsp_overflow  output  1  captured overflow flag
- rsp_div0  output  1  divide-by-zero response (see Optional Feature)
- busy  output  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0; state IDLE; alu_A/alu_B/alu_opcode = 0; all rsp_* = 0; rsp_valid = 0; busy = 0; cmd_ready = 1 once reset is released.
- FIFO: push on cmd_valid && cmd_ready. Pop only as described below. Simultaneous push and pop is allowed when full, but cmd_ready stays low while full, so no push occurs that cycle. Pointers wrap modulo DEPTH. FIFO order is preserved.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if FIFO non-empty, pop the head, register its operands into alu_A/alu_B/alu_opcode, and go to EXEC. If empty, stay in IDLE.
- EXEC, single cycle: the ALU settles combinationally. At the next edge:
  - capture rsp_result = alu_result and rsp_zero = alu_zero;
  - rsp_overflow = alu_overflow;
  - rsp_remainder = alu_remainder if alu_opcode == 111, else 0, which masks the ALU's stale remainder;
  - rsp_opcode = alu_opcode;
  - set rsp_valid = 1 and go to RESP.
- RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On handshake:
  - if FIFO non-empty, pop and load the next operands, then go directly to EXEC;
  - else clear rsp_valid and go to IDLE.
- Latency: a command pushed into an empty FIFO while IDLE at edge 0 is driven on alu_* after edge 1, and appears as rsp_valid after edge 2.
- Throughput: one response per 2 cycles with rsp_ready tied high.
- alu_* hold their last values between operations; they are not zeroed.
- Reset mid-operation drops the in-flight operation and all queued commands; no response is produced for them.

Optional Feature:
- Macro: ALU_SEQ_DIV0_TRAP_EN.
- Defined: a popped command with opcode 111 and b == 0 is not issued to the ALU; alu_* keep their previous values. After one EXEC cycle the response is:
  - rsp_result = all ones, rsp_remainder = cmd_a;
  - rsp_zero = 0, rsp_overflow = 1, rsp_div0 = 1.
  All other responses carry rsp_div0 = 0.
- Undefined: divide-by-zero is issued like any other command and the ALU outputs are captured as-is. rsp_div0 is tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC with 3 queued commands -> all rsp_* = 0, busy = 0, cmd_ready = 1; no response appears after release.
- Add 7+9: opcode 000 -> rsp_result = 0, rsp_zero = 1, rsp_overflow = 1, rsp_remainder = 0; rsp_valid exactly 2 edges after acceptance.
- Divide then AND: 13/4 followed by AND 0xC&0xA -> first response result 3, remainder 1; second response result 8, remainder 0 (stale remainder masked).
- Backpressure: push DEPTH+1 commands with rsp_ready = 0 -> cmd_ready falls after DEPTH+1 accepts (DEPTH in FIFO plus 1 in flight); rsp_* stable while stalled; all responses in order after release.
- Throughput: 8 commands with rsp_ready = 1 -> responses on every second cycle, order preserved, with FIFO wrap-around exercised.
- Div0 with ALU_SEQ_DIV0_TRAP_EN defined, 6/0 -> rsp_result = 0xF, rsp_remainder = 6, rsp_div0 = 1, rsp_overflow = 1, alu_* unchanged. With the macro undefined -> rsp_div0 = 0 and the ALU outputs are passed through.
